// File: rtl/aes_pkg.sv
// Shared AES GF(2^8) helpers and state geometry used by the MixColumns and
// InvMixColumns datapaths, plus the FSM encoding of the iterative inverse block.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;
  localparam int         COL_W    = 32;
  localparam int         STATE_W  = 128;
  localparam int         NUM_COLS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } imc_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  // Multiply by a 4-bit constant: sum of x, x2, x4, x8 selected by k's bits.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    gf_mul = (k[0] ? a  : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
             (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  // Column c occupies [127-32c -: 32]; column 0 is the most significant word.
  function automatic logic [COL_W-1:0] get_col(input logic [STATE_W-1:0] s,
                                               input logic [1:0]         c);
    get_col = s[STATE_W-1-COL_W*int'(c) -: COL_W];
  endfunction

endpackage

// File: rtl/inv_mix_column_word.sv
// Combinational InvMixColumns of one 32-bit column; row 0 is the top byte.
module inv_mix_column_word
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_i,
  output logic [COL_W-1:0] col_o
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] b0, b1, b2, b3;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  // Circulant rows of {0e, 0b, 0d, 09}.
  assign b0 = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
  assign b1 = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
  assign b2 = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
  assign b3 = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);

  assign col_o = {b0, b1, b2, b3};

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns: accepts a 128-bit state, transforms
// COLS_PER_CYCLE columns per clock in place, then presents the result.
module inv_mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and out_state is held while stalled.

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
    $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // STEP wraps to 0 for N=4, which is what the 2-bit counter needs.
  localparam logic [1:0] STEP      = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_BASE = 2'(NUM_COLS - COLS_PER_CYCLE);

  imc_state_e         state_q, state_d;
  logic [1:0]         col_cnt_q, col_cnt_d;
  logic [STATE_W-1:0] work_q, work_d;
  logic [STATE_W-1:0] work_upd;

  logic [1:0]       col_idx  [COLS_PER_CYCLE];
  logic [COL_W-1:0] cols_in  [COLS_PER_CYCLE];
  logic [COL_W-1:0] cols_out [COLS_PER_CYCLE];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign col_idx[g] = col_cnt_q + 2'(g);
    assign cols_in[g] = get_col(work_q, col_idx[g]);
    inv_mix_column_word u_word (
      .col_i (cols_in[g]),
      .col_o (cols_out[g])
    );
  end

  always_comb begin
    work_upd = work_q;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      work_upd[STATE_W-1-COL_W*int'(col_idx[g]) -: COL_W] = cols_out[g];
    end
  end

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    work_d    = work_q;
    in_ready  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d    = in_state;
          col_cnt_d = 2'd0;
          state_d   = ST_CALC;
        end
      end
      ST_CALC: begin
        work_d    = work_upd;
        col_cnt_d = col_cnt_q + STEP;
        if (col_cnt_q == LAST_BASE) begin
          col_cnt_d = 2'd0;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            work_d    = in_state;
            col_cnt_d = 2'd0;
            state_d   = ST_CALC;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Never advertise readiness while the block is held in reset.
    if (rst) in_ready = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      col_cnt_q <= 2'd0;
      work_q    <= '0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      work_q    <= work_d;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_CALC);
  assign out_state = work_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Bench for inv_mix_columns_seq at N=1,2,4 against a GF(2^8) matrix model.
module tb_inv_mix_columns_seq;

  localparam logic [127:0] FIPS_IN  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
  localparam logic [127:0] FIPS_OUT = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
  localparam logic [127:0] FIXED    = 128'h01010101_c6c6c6c6_00000000_ffffffff;
  localparam int           NRT      = 334;

  // Clock / reset and DUT wiring
  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_state  [3];
  logic [127:0] out_state [3];

  always #5 clk = ~clk;

  inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_state(in_state[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_state(out_state[0]), .busy(busy[0]));
  inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_state(in_state[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_state(out_state[1]), .busy(busy[1]));
  inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_state(in_state[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_state(out_state[2]), .busy(busy[2]));

  int ncols [3] = '{1, 2, 4};

  // Scoreboard state
  logic [127:0] exp_q [$];
  logic [127:0] exp_next;
  int           n_cmp = 0;
  int           n_fail = 0;
  int           sel = 0;
  int           cyc = 0;
  int           acc_cyc = 0;
  bit           have_acc = 0;
  bit           bp_en = 0;
  bit           pv = 0, pstall = 0;
  logic [127:0] pstate = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s (N=%0d): got %h, required %h", name, ncols[sel], act, req);
    end
  endtask

  // Reference model: plain matrix product over GF(2^8)
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] mat_apply(input logic [127:0] s, input logic [7:0] c0,
                                             input logic [7:0] c1, input logic [7:0] c2,
                                             input logic [7:0] c3);
    logic [7:0]   coef [4];
    logic [127:0] r;
    logic [7:0]   acc;
    coef = '{c0, c1, c2, c3};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(coef[(j - row + 4) % 4], s[127-32*c-8*j -: 8]);
        r[127-32*c-8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_mix_m(input logic [127:0] s);
    return mat_apply(s, 8'h0e, 8'h0b, 8'h0d, 8'h09);
  endfunction

  function automatic logic [127:0] mix_m(input logic [127:0] s);
    return mat_apply(s, 8'h02, 8'h03, 8'h01, 8'h01);
  endfunction

  function automatic logic [127:0] rand_state();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Compare process: runs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (out_valid[sel]) begin
        if (!pv && have_acc)
          chk("latency", 128'(cyc - acc_cyc), 128'(1 + 4 / ncols[sel]));
        if (pstall)
          chk("stall_stable", out_state[sel], pstate);
        if (out_ready[sel]) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", 128'(1), 128'(0));
          end else begin
            chk("out_state", out_state[sel], exp_q.pop_front());
          end
        end
      end
      if (in_valid[sel] && in_ready[sel]) begin
        exp_q.push_back(exp_next);
        acc_cyc  = cyc;
        have_acc = 1'b1;
      end
      pv     = out_valid[sel];
      pstall = out_valid[sel] && !out_ready[sel];
      pstate = out_state[sel];
    end else begin
      pv     = 1'b0;
      pstall = 1'b0;
    end
  end

  // Random backpressure on the selected DUT
  initial forever begin
    @(posedge clk);
    #2;
    if (bp_en) out_ready[sel] = ($urandom_range(0, 3) != 0);
  end

  // Driver tasks: called and return at 1 time unit after a rising edge.
  task automatic send(input int k, input logic [127:0] st, input logic [127:0] expv);
    int n;
    n = 0;
    exp_next    = expv;
    in_state[k] = st;
    in_valid[k] = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready[k]) break;
      n++;
      if (n > 100) begin
        chk("accept_timeout", 128'(0), 128'(1));
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid[k]) break;
      n++;
      if (n > 500) begin
        chk("drain_timeout", 128'(exp_q.size()), 128'(0));
        exp_q.delete();
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int k);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (out_valid[k]) break;
      n++;
      if (n > 20) begin
        chk("valid_timeout", 128'(0), 128'(1));
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] st;
    rst       = 1'b1;
    in_valid  = 3'b000;
    out_ready = 3'b111;
    for (int k = 0; k < 3; k++) in_state[k] = '0;
    exp_next = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      sel = k;
      chk("rst_in_ready", 128'(in_ready[k]), 128'(0));
      chk("rst_out_valid", 128'(out_valid[k]), 128'(0));
      chk("rst_busy", 128'(busy[k]), 128'(0));
      chk("rst_out_state", out_state[k], 128'(0));
    end
    sel = 0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("model_fips_inv", inv_mix_m(FIPS_IN), FIPS_OUT);
    chk("model_fips_fwd", mix_m(FIPS_OUT), FIPS_IN);
    chk("model_fixed", inv_mix_m(FIXED), FIXED);

    for (int k = 0; k < 3; k++) begin
      sel = k;
      have_acc = 1'b0;
      chk("idle_in_ready", 128'(in_ready[k]), 128'(1));

      // Known-answer vectors, with latency checked by the compare process
      send(k, FIPS_IN, FIPS_OUT);
      drain(k);
      send(k, FIXED, FIXED);
      drain(k);

      // Backpressure for 10 clocks
      out_ready[k] = 1'b0;
      st = rand_state();
      send(k, st, inv_mix_m(st));
      wait_valid(k);
      for (int i = 0; i < 10; i++) begin
        chk("stall_in_ready", 128'(in_ready[k]), 128'(0));
        chk("stall_out_valid", 128'(out_valid[k]), 128'(1));
        @(posedge clk);
        #1;
      end
      out_ready[k] = 1'b1;
      @(posedge clk);
      #1;
      chk("post_xfer_out_valid", 128'(out_valid[k]), 128'(0));
      chk("post_xfer_in_ready", 128'(in_ready[k]), 128'(1));
      chk("post_xfer_queue", 128'(exp_q.size()), 128'(0));

      // Back-to-back: three queued states, in_valid never drops between them
      for (int i = 0; i < 3; i++) begin
        st = rand_state();
        send(k, st, inv_mix_m(st));
      end
      drain(k);

      // Reset two columns into the calculation
      send(k, rand_state(), 128'(0));
      repeat (2 / ncols[k]) begin
        @(posedge clk);
        #1;
      end
      rst = 1'b1;
      #1;
      chk("midcalc_rst_out_valid", 128'(out_valid[k]), 128'(0));
      chk("midcalc_rst_in_ready", 128'(in_ready[k]), 128'(0));
      chk("midcalc_rst_busy", 128'(busy[k]), 128'(0));
      exp_q.delete();
      have_acc = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk);
        #1;
        chk("no_stale_output", 128'(out_valid[k]), 128'(0));
      end
      st = rand_state();
      send(k, st, inv_mix_m(st));
      drain(k);

      // Round trip: MixColumns in the model, inverse in the DUT
      bp_en = 1'b1;
      for (int i = 0; i < NRT; i++) begin
        st = rand_state();
        send(k, mix_m(st), st);
      end
      drain(k);
      bp_en = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 3'b111;
      drain(k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
